// File: rtl/ifetch_stage.sv
// RV32 instruction-fetch stage: owns the PC, addresses the instruction ROM and fills IF/ID.
// Optional macro IFETCH_MISALIGN_CHK_EN adds misalign_err and refuses misaligned redirects.
module ifetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_data,
    output logic [DATA_WIDTH-1:0] if_id_pc,
    output logic [DATA_WIDTH-1:0] if_id_instr,
    output logic                  if_id_valid,
`ifdef IFETCH_MISALIGN_CHK_EN
    output logic                  misalign_err,
`endif
    output logic                  halted
);

    localparam logic [DATA_WIDTH-1:0] EBREAK_INSTR = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t                state_r;
    logic [DATA_WIDTH-1:0] pc_r;
    logic [DATA_WIDTH-1:0] pc_inc_s;
    logic [DATA_WIDTH-1:0] redirect_target_s;
    logic                  misaligned_s;

    assign imem_addr = pc_r;

    // Sequential-address and redirect-target helpers; target is always word aligned.
    always_comb begin
        pc_inc_s          = pc_r + DATA_WIDTH'(4);
        redirect_target_s = redirect_pc & ~DATA_WIDTH'(3);
`ifdef IFETCH_MISALIGN_CHK_EN
        misaligned_s      = (redirect_pc[1:0] != 2'b00);
`else
        misaligned_s      = 1'b0;
`endif
    end

    // Fetch FSM together with PC and the IF/ID pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            pc_r         <= RESET_PC;
            if_id_pc     <= '0;
            if_id_instr  <= NOP_INSTR;
            if_id_valid  <= 1'b0;
            halted       <= 1'b0;
`ifdef IFETCH_MISALIGN_CHK_EN
            misalign_err <= 1'b0;
`endif
        end else begin
`ifdef IFETCH_MISALIGN_CHK_EN
            misalign_err <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if_id_valid <= 1'b0;
                    if_id_instr <= NOP_INSTR;
                    if (start) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (redirect) begin
                        // Wrong-path word in flight is dropped; target fetched next edge.
                        if_id_valid <= 1'b0;
                        if_id_instr <= NOP_INSTR;
                        if (misaligned_s) begin
                            state_r <= ST_HALT;
                            halted  <= 1'b1;
`ifdef IFETCH_MISALIGN_CHK_EN
                            misalign_err <= 1'b1;
`endif
                        end else begin
                            pc_r <= redirect_target_s;
                        end
                    end else if (flush) begin
                        if_id_valid <= 1'b0;
                        if_id_instr <= NOP_INSTR;
                        pc_r        <= pc_inc_s;
                    end else if (stall) begin
                        pc_r <= pc_r;
                    end else begin
                        if_id_pc    <= pc_r;
                        if_id_instr <= imem_data;
                        if_id_valid <= 1'b1;
                        pc_r        <= pc_inc_s;
                        if (imem_data == EBREAK_INSTR) begin
                            state_r <= ST_HALT;
                            halted  <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    if_id_valid <= 1'b0;
                    if_id_instr <= NOP_INSTR;
                    if (redirect) begin
                        if (misaligned_s) begin
`ifdef IFETCH_MISALIGN_CHK_EN
                            misalign_err <= 1'b1;
`endif
                            state_r <= ST_HALT;
                        end else begin
                            pc_r    <= redirect_target_s;
                            state_r <= ST_RUN;
                            halted  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    halted      <= 1'b0;
                    if_id_valid <= 1'b0;
                    if_id_instr <= NOP_INSTR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_stage.sv
// Self-checking bench for ifetch_stage: directed scenarios plus randomized traffic
// compared every cycle against a flag/arithmetic model of the fetch rules.
module tb_ifetch_stage;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
`ifdef IFETCH_MISALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        halted;
    logic        misalign_err;

    logic [31:0] rom [64];
    int          n_cmp;
    int          n_err;

    ifetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid),
`ifdef IFETCH_MISALIGN_CHK_EN
        .misalign_err(misalign_err),
`endif
        .halted      (halted)
    );

`ifndef IFETCH_MISALIGN_CHK_EN
    assign misalign_err = 1'b0;
`endif

    assign imem_data = rom[imem_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: "running"/"halted" flags plus plain PC arithmetic.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ifpc;
        logic [31:0] ifinstr;
        logic        valid;
        logic        run;
        logic        halt;
        logic        merr;
    } model_t;

    model_t m;

    function automatic model_t model_next(model_t c, logic st, logic sl, logic fl,
                                          logic rd, logic [31:0] rpc, logic [31:0] word);
        model_t n;
        logic   bad;
        n      = c;
        n.merr = 1'b0;
        bad    = CHK && (rpc[1:0] != 2'b00);
        if (c.halt) begin
            n.valid = 1'b0; n.ifinstr = NOP;
            if (rd) begin
                if (bad) n.merr = 1'b1;
                else begin n.pc = {rpc[31:2], 2'b00}; n.halt = 1'b0; n.run = 1'b1; end
            end
        end else if (!c.run) begin
            n.valid = 1'b0; n.ifinstr = NOP;
            if (st) n.run = 1'b1;
        end else if (rd) begin
            n.valid = 1'b0; n.ifinstr = NOP;
            if (bad) begin n.merr = 1'b1; n.run = 1'b0; n.halt = 1'b1; end
            else n.pc = {rpc[31:2], 2'b00};
        end else if (fl) begin
            n.valid = 1'b0; n.ifinstr = NOP;
            n.pc = c.pc + 32'd4;
        end else if (!sl) begin
            n.ifpc = c.pc; n.ifinstr = word; n.valid = 1'b1;
            n.pc = c.pc + 32'd4;
            if (word == EBREAK) begin n.run = 1'b0; n.halt = 1'b1; end
        end
        return n;
    endfunction

    // Model state advances on the same edges as the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= '{pc: 32'h0, ifpc: 32'h0, ifinstr: NOP, valid: 1'b0,
                   run: 1'b0, halt: 1'b0, merr: 1'b0};
        end else begin
            m <= model_next(m, start, stall, flush, redirect, redirect_pc, rom[m.pc[7:2]]);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison, mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("imem_addr", imem_addr, m.pc);
            chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m.valid});
            chk("if_id_instr", if_id_instr, m.ifinstr);
            chk("halted", {31'd0, halted}, {31'd0, m.halt});
            if (m.valid) chk("if_id_pc", if_id_pc, m.ifpc);
            if (CHK) chk("misalign_err", {31'd0, misalign_err}, {31'd0, m.merr});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; flush = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0;
        for (int i = 0; i < 64; i++) begin
            rom[i] = $urandom;
            if (rom[i] == EBREAK) rom[i] = rom[i] ^ 32'h0000_0100;
        end
        rom[4] = EBREAK;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", imem_addr, 32'h0);
        rst_n = 1'b1;

        // Start, then sequential fetch 0,4
        start = 1'b1;
        cyc();
        chk("start_valid", {31'd0, if_id_valid}, 32'd0);
        start = 1'b0;
        cyc();
        chk("seq_pc0", if_id_pc, 32'h0);
        chk("seq_instr0", if_id_instr, rom[0]);
        cyc();
        chk("seq_pc4", if_id_pc, 32'h4);

        // Stall three cycles at pc=8
        stall = 1'b1;
        repeat (3) begin
            cyc();
            chk("stall_pc", imem_addr, 32'h8);
            chk("stall_ifpc", if_id_pc, 32'h4);
        end
        stall = 1'b0;
        cyc();
        chk("resume_pc8", if_id_pc, 32'h8);

        // Redirect to 0x40 at pc=12
        redirect = 1'b1; redirect_pc = 32'h40;
        cyc();
        chk("redir_bubble", {31'd0, if_id_valid}, 32'd0);
        chk("redir_nop", if_id_instr, NOP);
        redirect = 1'b0;
        cyc();
        chk("redir_target", if_id_pc, 32'h40);

        // Redirect beats stall, then run into EBREAK at 0x10
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'hC;
        cyc();
        chk("redir_stall_pc", imem_addr, 32'hC);
        redirect = 1'b0; stall = 1'b0;
        cyc();
        cyc();
        chk("ebreak_instr", if_id_instr, EBREAK);
        chk("ebreak_halted", {31'd0, halted}, 32'd1);
        cyc();
        chk("halt_pc", imem_addr, 32'h14);
        chk("halt_valid", {31'd0, if_id_valid}, 32'd0);
        redirect = 1'b1; redirect_pc = 32'h0;
        cyc();
        chk("unhalt", {31'd0, halted}, 32'd0);
        redirect = 1'b0;
        cyc();
        chk("restart_pc0", if_id_pc, 32'h0);

        // Async reset mid-run at pc=0x20
        redirect = 1'b1; redirect_pc = 32'h1C;
        cyc();
        redirect = 1'b0;
        cyc();
        chk("pre_rst_pc", imem_addr, 32'h20);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pc", imem_addr, 32'h0);
        chk("arst_ifpc", if_id_pc, 32'h0);
        chk("arst_instr", if_id_instr, NOP);
        chk("arst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("arst_halted", {31'd0, halted}, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("idle_pc", imem_addr, 32'h0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        chk("restart_valid", {31'd0, if_id_valid}, 32'd1);

        // Misaligned redirect from pc=4
        redirect = 1'b1; redirect_pc = 32'h42;
        cyc();
        if (CHK) begin
            chk("mis_pc_held", imem_addr, 32'h4);
            chk("mis_err", {31'd0, misalign_err}, 32'd1);
            chk("mis_halted", {31'd0, halted}, 32'd1);
        end else begin
            chk("mis_pc_aligned", imem_addr, 32'h40);
        end
        redirect = 1'b0;
        cyc();
        if (CHK) chk("mis_err_pulse", {31'd0, misalign_err}, 32'd0);

        // PC wrap at top of address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cyc();
        redirect = 1'b0;
        cyc();
        chk("wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);
        chk("wrap_pc", imem_addr, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom_range(0, 99) < 3);
            stall    = ($urandom_range(0, 99) < 20);
            flush    = ($urandom_range(0, 99) < 10);
            redirect = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 99) < 5) redirect_pc = 32'hFFFF_FFFC;
            else redirect_pc = 32'($urandom_range(0, 255));
            cyc();
        end
        start = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
